// File: rtl/fifo_push_arb.sv
// Round-robin arbiter sharing one fifo write port among NREQ burst producers.
// Optional macro FIFO_PUSH_ARB_STALL_CNT_EN adds a saturating fifo-full stall counter.
module fifo_push_arb #(
  parameter int LOG2_NREQ = 2,
  parameter int DWIDTH    = 16,
  parameter int MAX_BURST = 4,
  localparam int NREQ     = 1 << LOG2_NREQ
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DWIDTH-1:0]    req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic [DWIDTH+LOG2_NREQ-1:0] fifo_din,
  output logic                      fifo_push,
  input  logic                      fifo_full,
  output logic [LOG2_NREQ-1:0]      grant_id,
  output logic                      busy
`ifdef FIFO_PUSH_ARB_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam logic [7:0] MAX_BEATS = 8'(MAX_BURST);

  state_e                 state_q, state_d;
  logic [LOG2_NREQ-1:0]   grant_q, grant_d;
  logic [LOG2_NREQ-1:0]   ptr_q, ptr_d;
  logic [7:0]             beat_q, beat_d;
  logic [7:0]             beat_inc_s;
  logic                   xfer_s;

  // First valid requester at or above ptr, wrapping modulo NREQ.
  function automatic logic [LOG2_NREQ-1:0] rr_pick(
    input logic [NREQ-1:0]      valid,
    input logic [LOG2_NREQ-1:0] ptr
  );
    logic [LOG2_NREQ-1:0] idx;
    logic                 found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + LOG2_NREQ'(k);
      if (!found && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

  // State, grant, pointer and beat registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      beat_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    beat_d     = beat_q;
    req_ready  = '0;
    xfer_s     = 1'b0;
    beat_inc_s = beat_q + 8'd1;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d = rr_pick(req_valid, ptr_q);
          beat_d  = 8'd0;
          state_d = ST_BURST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        req_ready[grant_q] = ~fifo_full;
        xfer_s             = req_valid[grant_q] & ~fifo_full;
        if (xfer_s) begin
          beat_d = beat_inc_s;
          if (req_last[grant_q] || (beat_inc_s == MAX_BEATS)) begin
            state_d = ST_IDLE;
            ptr_d   = grant_q + LOG2_NREQ'(1);
          end else begin
            state_d = ST_BURST;
          end
        end else if (!req_valid[grant_q] && !fifo_full) begin
          // Requester went idle mid-burst: give up the port.
          state_d = ST_IDLE;
          ptr_d   = grant_q + LOG2_NREQ'(1);
        end else begin
          beat_d  = beat_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign fifo_push = xfer_s;
  assign fifo_din  = {grant_q, req_data[grant_q*DWIDTH +: DWIDTH]};
  assign grant_id  = grant_q;
  assign busy      = (state_q == ST_BURST);

`ifdef FIFO_PUSH_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles the granted requester waits on a full fifo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else if ((state_q == ST_BURST) && req_valid[grant_q] && fifo_full &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed and randomized bench for fifo_push_arb against a behavioural reference model.
module tb_fifo_push_arb;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [17:0] fifo_din;
  logic        fifo_push;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_PUSH_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_busy, m_gid, m_ptr, m_beats, m_stall;
  int last_xfer;
  int cnt[4];
  int rem[4];
  bit lastflag[4];
  logic [17:0] pushed[$];

  fifo_push_arb #(.LOG2_NREQ(2), .DWIDTH(16), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_din  (fifo_din),
    .fifo_push (fifo_push),
    .fifo_full (fifo_full),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef FIFO_PUSH_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_ptr = 0; m_beats = 0; m_stall = 0; last_xfer = -1;
  endtask

  task automatic set_data(input int i);
    req_data[i*16 +: 16] = 16'(32'h1000 * i + cnt[i]);
  endtask

  task automatic bump();
    if (last_xfer >= 0) begin
      cnt[last_xfer]++;
      set_data(last_xfer);
    end
  endtask

  // One clock: compare DUT against the model at negedge, advance the model, return at posedge+1.
  task automatic step();
    logic [3:0]  er;
    logic        ex;
    logic [1:0]  g2;
    logic [17:0] ed;
    bit          found;
    @(negedge clk);
    er = 4'b0000;
    ex = 1'b0;
    g2 = 2'(m_gid);
    if (m_busy != 0) begin
      er[m_gid] = ~fifo_full;
      ex = req_valid[m_gid] & ~fifo_full;
    end
    check("ready", 32'(req_ready), 32'(er));
    check("push",  32'(fifo_push), 32'(ex));
    check("busy",  32'(busy),      32'(m_busy));
    check("grant", 32'(grant_id),  32'(m_gid));
    if (ex) begin
      ed = {g2, req_data[m_gid*16 +: 16]};
      check("din", 32'(fifo_din), 32'(ed));
    end
    if (fifo_push === 1'b1) pushed.push_back(fifo_din);
    if ((m_busy != 0) && req_valid[m_gid] && fifo_full && (m_stall < 65535)) m_stall++;
    last_xfer = -1;
    if (m_busy == 0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && req_valid[(m_ptr + k) % 4]) begin
          m_gid = (m_ptr + k) % 4;
          found = 1;
        end
      end
      if (found) begin
        m_busy = 1;
        m_beats = 0;
      end
    end else begin
      if (ex) begin
        last_xfer = m_gid;
        m_beats++;
      end
      if ((ex && (req_last[m_gid] || m_beats == MAXB)) || (!req_valid[m_gid] && !fifo_full)) begin
        m_busy = 0;
        m_ptr = (m_gid + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Random producers: advance on accept, hold while granted, toggle freely otherwise.
  task automatic producers();
    for (int i = 0; i < 4; i++) begin
      if (last_xfer == i) begin
        cnt[i]++;
        rem[i]--;
        if (rem[i] == 0) req_valid[i] = 1'b0;
      end else if (!((m_busy != 0) && (m_gid == i))) begin
        if (rem[i] == 0) begin
          if ($urandom_range(0, 2) == 0) begin
            rem[i] = $urandom_range(1, 6);
            lastflag[i] = 1'($urandom_range(0, 1));
            req_valid[i] = 1'b1;
          end
        end else begin
          req_valid[i] = ($urandom_range(0, 7) != 0);
        end
      end
      req_last[i] = req_valid[i] && lastflag[i] && (rem[i] == 1);
      set_data(i);
    end
  endtask

  initial begin
    int n0;
    logic [17:0] ew;
    reset = 1'b1;
    req_valid = 4'b0000;
    req_last = 4'b0000;
    req_data = 64'h0;
    req_data[15:0] = 16'hBEEF;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; rem[i] = 0; lastflag[i] = 0; end
    model_reset();

    // Reset state
    @(posedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_push",  32'(fifo_push), 32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    check("rst_grant", 32'(grant_id),  32'h0);
    check("rst_din",   32'(fifo_din),  32'h0BEEF);
    reset = 1'b0;

    // All four continuously valid, never last: 4-word bursts 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_data(i);
    req_valid = 4'b1111;
    pushed.delete();
    repeat (25) begin step(); bump(); end
    req_valid = 4'b0000;
    step();
    check("rr_count", 32'(pushed.size()), 32'd20);
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 4; w++) begin
        ew = 18'(((b % 4) << 16) | ((b % 4) * 32'h1000 + (b / 4) * 4 + w));
        if (pushed.size() > b * 4 + w) check("rr_word", 32'(pushed[b*4+w]), 32'(ew));
      end
    end

    // Single requester 2, three words with last on the third
    pushed.delete();
    req_valid[2] = 1'b1;
    req_data[47:32] = 16'hA001;
    step();
    check("t1_grant", 32'(grant_id), 32'd2);
    step(); req_data[47:32] = 16'hA002;
    step(); req_data[47:32] = 16'hA003; req_last[2] = 1'b1;
    step(); req_valid[2] = 1'b0; req_last[2] = 1'b0;
    check("t1_busy_drop", 32'(busy), 32'd0);
    step();
    check("t1_count", 32'(pushed.size()), 32'd3);
    if (pushed.size() == 3) begin
      check("t1_w0", 32'(pushed[0]), 32'h2A001);
      check("t1_w1", 32'(pushed[1]), 32'h2A002);
      check("t1_w2", 32'(pushed[2]), 32'h2A003);
    end

    // Asynchronous reset mid-burst, then arbitration restarts from pointer 0
    req_valid[0] = 1'b1;
    set_data(0);
    step();
    check("t5_grant", 32'(grant_id), 32'd0);
    step(); bump();
    #2;
    reset = 1'b1;
    #1;
    check("t5_ready", 32'(req_ready), 32'h0);
    check("t5_push",  32'(fifo_push), 32'h0);
    check("t5_busy",  32'(busy),      32'h0);
    model_reset();
    @(posedge clk); #1;
    check("t5_push_hold", 32'(fifo_push), 32'h0);
    reset = 1'b0;

    // Requester 0 goes idle after one word while 3 waits: next grant is 3
    req_valid[3] = 1'b1;
    req_last[3] = 1'b1;
    set_data(3);
    step();
    check("t4_first", 32'(grant_id), 32'd0);
    step(); bump();
    req_valid[0] = 1'b0;
    step();
    step();
    check("t4_next", 32'(grant_id), 32'd3);
    step(); bump();
    req_valid[3] = 1'b0; req_last[3] = 1'b0;
    step();

    // Requester 1 stalled by fifo_full for 5 cycles after its 2nd word
    req_valid[1] = 1'b1;
    set_data(1);
    step();
    check("t3_grant", 32'(grant_id), 32'd1);
    step(); bump();
    step(); bump();
    fifo_full = 1'b1;
    n0 = pushed.size();
    repeat (5) begin
      step();
      check("t3_stall_ready", 32'(req_ready), 32'h0);
    end
    check("t3_stall_nopush", 32'(pushed.size()), 32'(n0));
    fifo_full = 1'b0;
    step(); bump();
    step(); bump();
    check("t3_resume", 32'(pushed.size()), 32'(n0 + 2));
    req_valid[1] = 1'b0;
`ifdef FIFO_PUSH_ARB_STALL_CNT_EN
    check("t3_stall_cnt", 32'(stall_cnt), 32'd5);
`endif
    step();

    // Requesters 1 and 3 with pointer at 2: 3 wins, then wrap to 1
    req_valid[1] = 1'b1; req_last[1] = 1'b1;
    req_valid[3] = 1'b1; req_last[3] = 1'b1;
    step();
    check("t6_first", 32'(grant_id), 32'd3);
    step(); bump();
    req_valid[3] = 1'b0; req_last[3] = 1'b0;
    step();
    check("t6_second", 32'(grant_id), 32'd1);
    step(); bump();
    req_valid[1] = 1'b0; req_last[1] = 1'b0;
    step();

    // Randomized producers and fifo backpressure
    for (int i = 0; i < 4; i++) set_data(i);
    repeat (400) begin
      step();
      producers();
      fifo_full = ($urandom_range(0, 3) == 0);
    end
    req_valid = 4'b0000;
    req_last = 4'b0000;
    fifo_full = 1'b0;
    repeat (3) step();
`ifdef FIFO_PUSH_ARB_STALL_CNT_EN
    check("stall_cnt_final", 32'(stall_cnt), 32'(m_stall));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
